// File: rtl/vga_frame_sync_ctrl.sv
// ---------------------------------------------------------------------------
// vga_frame_sync_ctrl
//
// Sits between the Avalon-MM slave and the VGA pixel datapath. CPU writes
// to the background colour and ball position go into shadow registers.
// All of them are copied to the active outputs together, one cycle after
// the last pixel of the last active line. This way a frame never shows a
// half-applied update. The block also keeps a free-running frame counter,
// a pending/commit status and a sticky vblank interrupt.
//
// Ports:
//   clk, reset           system clock, asynchronous active-high reset
//   chipselect, write,   Avalon-MM slave strobes
//   read
//   address[3:0]         register index
//   writedata[7:0]       write data
//   readdata[7:0]        registered read data (one cycle after read)
//   hcount[10:0],        position from the VGA timing counters
//   vcount[9:0]
//   bg_r/bg_g/bg_b       committed background colour
//   ball_x/ball_y        committed ball position
//   frame_sync           one-cycle pulse, the cycle after the boundary
//   irq                  sticky level interrupt
// ---------------------------------------------------------------------------
module vga_frame_sync_ctrl #(
   parameter int         HTOTAL     = 1600,
   parameter int         VACTIVE    = 480,
   parameter logic [7:0] BG_B_RESET = 8'h80
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        chipselect,
   input  logic        write,
   input  logic        read,
   input  logic [3:0]  address,
   input  logic [7:0]  writedata,
   output logic [7:0]  readdata,
   input  logic [10:0] hcount,
   input  logic [9:0]  vcount,
   output logic [7:0]  bg_r,
   output logic [7:0]  bg_g,
   output logic [7:0]  bg_b,
   output logic [7:0]  ball_x,
   output logic [7:0]  ball_y,
   output logic        frame_sync,
   output logic        irq
);

   localparam logic [10:0] H_LAST = 11'(HTOTAL - 1);
   localparam logic [9:0]  V_LAST = 10'(VACTIVE - 1);

   localparam logic [1:0] ST_CLEAN  = 2'd0;
   localparam logic [1:0] ST_DIRTY  = 2'd1;
   localparam logic [1:0] ST_COMMIT = 2'd2;

   logic [1:0] state, next_state;
   logic [7:0] sh_bg_r, sh_bg_g, sh_bg_b, sh_ball_x, sh_ball_y;
   logic [1:0] ctrl;
   logic [7:0] frame_cnt;
   logic [7:0] read_mux;
   logic       boundary, wr_sel, wr_shadow, pending;

   // The boundary is the very last clock of the last active line.
   assign boundary  = (hcount == H_LAST) && (vcount == V_LAST);
   assign wr_sel    = chipselect && write;
   assign wr_shadow = wr_sel && (address <= 4'd4);
   assign pending   = (state != ST_CLEAN);

   // Commit sequencing. A shadow write that lands on the boundary cycle
   // itself still commits at that boundary, because the shadow register
   // takes the new value on the same edge that enters COMMIT. A write
   // during COMMIT misses this copy, so it re-arms DIRTY.
   always_comb begin
      next_state = state;
      case (state)
         ST_CLEAN: begin
            if (wr_shadow) begin
               if (boundary && !ctrl[0])
                  next_state = ST_COMMIT;
               else
                  next_state = ST_DIRTY;
            end
         end
         ST_DIRTY: begin
            if (boundary && !ctrl[0])
               next_state = ST_COMMIT;
         end
         ST_COMMIT: begin
            next_state = wr_shadow ? ST_DIRTY : ST_CLEAN;
         end
         default: next_state = ST_CLEAN;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= ST_CLEAN;
      else
         state <= next_state;
   end

   // CPU-visible shadow and control registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sh_bg_r   <= 8'h00;
         sh_bg_g   <= 8'h00;
         sh_bg_b   <= BG_B_RESET;
         sh_ball_x <= 8'h00;
         sh_ball_y <= 8'h00;
         ctrl      <= 2'b00;
      end else if (wr_sel) begin
         case (address)
            4'd0: sh_bg_r   <= writedata;
            4'd1: sh_bg_g   <= writedata;
            4'd2: sh_bg_b   <= writedata;
            4'd3: sh_ball_x <= writedata;
            4'd4: sh_ball_y <= writedata;
            4'd5: ctrl      <= writedata[1:0];
            default: ;
         endcase
      end
   end

   // Active registers only move on the COMMIT edge. They pick up the shadow
   // contents from before any write made in that same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bg_r   <= 8'h00;
         bg_g   <= 8'h00;
         bg_b   <= BG_B_RESET;
         ball_x <= 8'h00;
         ball_y <= 8'h00;
      end else if (state == ST_COMMIT) begin
         bg_r   <= sh_bg_r;
         bg_g   <= sh_bg_g;
         bg_b   <= sh_bg_b;
         ball_x <= sh_ball_x;
         ball_y <= sh_ball_y;
      end
   end

   // Frame counter, sync pulse and interrupt. The set path of irq has
   // priority, so a clear that races the boundary does not lose an event.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_cnt  <= 8'h00;
         frame_sync <= 1'b0;
         irq        <= 1'b0;
      end else begin
         frame_sync <= boundary;
         if (boundary)
            frame_cnt <= frame_cnt + 8'd1;
         if (boundary && ctrl[1])
            irq <= 1'b1;
         else if (wr_sel && (address == 4'd6) && writedata[1])
            irq <= 1'b0;
      end
   end

   // Read-back mux. Addresses 0..4 return the shadow values.
   always_comb begin
      read_mux = 8'h00;
      case (address)
         4'd0: read_mux = sh_bg_r;
         4'd1: read_mux = sh_bg_g;
         4'd2: read_mux = sh_bg_b;
         4'd3: read_mux = sh_ball_x;
         4'd4: read_mux = sh_ball_y;
         4'd5: read_mux = {6'b0, ctrl};
         4'd6: read_mux = {6'b0, irq, pending};
         4'd7: read_mux = frame_cnt;
         default: read_mux = 8'h00;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         readdata <= 8'h00;
      else if (chipselect && read)
         readdata <= read_mux;
   end

endmodule

// File: tb/tb_vga_frame_sync_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vga_frame_sync_ctrl
//
// Drives the commit controller with directed scenarios and a random phase.
// The VGA counters are driven directly, so a frame boundary can be placed
// on any chosen cycle. A behavioural model tracks the register file:
//   - a dirty flag
//   - a commit scheduled for the next cycle
//   - frame count, irq and read-back
// ---------------------------------------------------------------------------
module tb_vga_frame_sync_ctrl;

   localparam int         HTOTAL     = 1600;
   localparam int         VACTIVE    = 480;
   localparam logic [7:0] BG_B_RESET = 8'h80;

   logic        clk = 1'b0;
   logic        reset;
   logic        chipselect, write, read;
   logic [3:0]  address;
   logic [7:0]  writedata;
   logic [7:0]  readdata;
   logic [10:0] hcount;
   logic [9:0]  vcount;
   logic [7:0]  bg_r, bg_g, bg_b, ball_x, ball_y;
   logic        frame_sync, irq;

   int checks = 0;
   int errors = 0;

   // Model state
   logic [7:0] m_sh  [5];
   logic [7:0] m_act [5];
   logic [1:0] m_ctrl;
   logic       m_irq, m_sync, m_dirty, m_sched;
   logic [7:0] m_cnt, m_rd;

   vga_frame_sync_ctrl #(
      .HTOTAL(HTOTAL), .VACTIVE(VACTIVE), .BG_B_RESET(BG_B_RESET)
   ) dut (
      .clk(clk), .reset(reset), .chipselect(chipselect), .write(write),
      .read(read), .address(address), .writedata(writedata),
      .readdata(readdata), .hcount(hcount), .vcount(vcount),
      .bg_r(bg_r), .bg_g(bg_g), .bg_b(bg_b), .ball_x(ball_x),
      .ball_y(ball_y), .frame_sync(frame_sync), .irq(irq)
   );

   always #5 clk = ~clk;

   // Returns the model to its power-on contents.
   task automatic model_reset();
      for (int i = 0; i < 5; i++) begin
         m_sh[i]  = 8'h00;
         m_act[i] = 8'h00;
      end
      m_sh[2]  = BG_B_RESET;
      m_act[2] = BG_B_RESET;
      m_ctrl = 2'b00; m_irq = 1'b0; m_sync = 1'b0;
      m_dirty = 1'b0; m_sched = 1'b0; m_cnt = 8'h00; m_rd = 8'h00;
   endtask

   // Puts the counters at a random position that is not the boundary.
   task automatic set_idle();
      hcount = 11'($urandom_range(0, HTOTAL - 1));
      vcount = 10'($urandom_range(0, 524));
      if (hcount == 11'(HTOTAL - 1) && vcount == 10'(VACTIVE - 1))
         hcount = 11'd0;
   endtask

   task automatic set_b();
      hcount = 11'(HTOTAL - 1);
      vcount = 10'(VACTIVE - 1);
   endtask

   // Advances the model by one clock, using the inputs that the DUT sees.
   task automatic model_step();
      logic       b, wsel, wr_sh, was, new_sched;
      logic [7:0] rv;
      b     = (hcount == 11'(HTOTAL - 1)) && (vcount == 10'(VACTIVE - 1));
      wsel  = chipselect && write;
      wr_sh = wsel && (address <= 4'd4);
      was   = m_sched;
      if (address <= 4'd4)      rv = m_sh[address];
      else if (address == 4'd5) rv = {6'b0, m_ctrl};
      else if (address == 4'd6) rv = {6'b0, m_irq, (m_dirty || m_sched)};
      else if (address == 4'd7) rv = m_cnt;
      else                      rv = 8'h00;
      if (chipselect && read) m_rd = rv;
      if (was)
         for (int i = 0; i < 5; i++) m_act[i] = m_sh[i];
      new_sched = !was && b && !m_ctrl[0] && (m_dirty || wr_sh);
      if (new_sched)  m_dirty = 1'b0;
      else if (wr_sh) m_dirty = 1'b1;
      if (b && m_ctrl[1])                               m_irq = 1'b1;
      else if (wsel && address == 4'd6 && writedata[1]) m_irq = 1'b0;
      if (b) m_cnt = m_cnt + 8'd1;
      m_sync = b;
      if (wr_sh) m_sh[address] = writedata;
      if (wsel && address == 4'd5) m_ctrl = writedata[1:0];
      m_sched = new_sched;
   endtask

   // Applies the current inputs on one edge, then returns the bus to idle.
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      chipselect = 1'b0; write = 1'b0; read = 1'b0;
      address = 4'd0; writedata = 8'd0;
      set_idle();
   endtask

   task automatic do_write(input logic [3:0] a, input logic [7:0] d);
      chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
      tick();
   endtask

   task automatic do_read(input logic [3:0] a);
      chipselect = 1'b1; read = 1'b1; address = a;
      tick();
   endtask

   task automatic test_reset();
      do_write(4'd2, 8'h33);
      do_read(4'd2);
      checks++;
      if (readdata !== 8'h33) begin
         errors++;
         $display("[TB] FAIL rst_pre_read got %h want 33", readdata);
      end
      do_write(4'd3, 8'h55);
      set_b();
      tick();
      // The DUT is now in its commit cycle. Reset must win with no copy.
      reset = 1'b1;
      #1;
      model_reset();
      checks++;
      if ({bg_r, bg_g, bg_b, ball_x, ball_y} !== {16'h0000, BG_B_RESET, 16'h0000}) begin
         errors++;
         $display("[TB] FAIL rst_outputs got %h%h%h%h%h want 0000%h0000",
                  bg_r, bg_g, bg_b, ball_x, ball_y, BG_B_RESET);
      end
      checks++;
      if ({irq, frame_sync, readdata} !== 10'd0) begin
         errors++;
         $display("[TB] FAIL rst_misc irq=%b sync=%b rd=%h want 0 0 00",
                  irq, frame_sync, readdata);
      end
      #1;
      reset = 1'b0;
      tick();
      checks++;
      if (ball_x !== 8'h00) begin
         errors++;
         $display("[TB] FAIL rst_no_partial_copy ball_x got %h want 00", ball_x);
      end
      do_read(4'd6);
      checks++;
      if (readdata !== 8'h00) begin
         errors++;
         $display("[TB] FAIL rst_status got %h want 00", readdata);
      end
   endtask

   task automatic test_commit();
      do_write(4'd3, 8'h20);
      checks++;
      if (ball_x !== 8'h00) begin
         errors++;
         $display("[TB] FAIL commit_early ball_x got %h want 00", ball_x);
      end
      do_read(4'd6);
      checks++;
      if (readdata !== 8'h01) begin
         errors++;
         $display("[TB] FAIL commit_pending status got %h want 01", readdata);
      end
      set_b();
      tick();
      checks++;
      if (frame_sync !== 1'b1 || ball_x !== 8'h00) begin
         errors++;
         $display("[TB] FAIL commit_b_edge sync=%b ball_x=%h want 1 00",
                  frame_sync, ball_x);
      end
      tick();
      checks++;
      if (ball_x !== 8'h20 || frame_sync !== 1'b0) begin
         errors++;
         $display("[TB] FAIL commit_done ball_x=%h sync=%b want 20 0",
                  ball_x, frame_sync);
      end
      do_read(4'd6);
      checks++;
      if (readdata !== 8'h00) begin
         errors++;
         $display("[TB] FAIL commit_clean status got %h want 00", readdata);
      end
   endtask

   task automatic test_hold();
      do_write(4'd5, 8'h01);
      do_write(4'd0, 8'hFF);
      for (int i = 0; i < 2; i++) begin
         set_b();
         tick();
         tick();
      end
      do_read(4'd6);
      checks++;
      if (bg_r !== 8'h00 || readdata !== 8'h01) begin
         errors++;
         $display("[TB] FAIL hold_blocks bg_r=%h status=%h want 00 01",
                  bg_r, readdata);
      end
      do_write(4'd5, 8'h00);
      tick();
      checks++;
      if (bg_r !== 8'h00) begin
         errors++;
         $display("[TB] FAIL hold_release_early bg_r got %h want 00", bg_r);
      end
      set_b();
      tick();
      tick();
      checks++;
      if (bg_r !== 8'hFF) begin
         errors++;
         $display("[TB] FAIL hold_release bg_r got %h want ff", bg_r);
      end
   endtask

   task automatic test_back_to_back();
      // Write on the boundary cycle, then again on the commit cycle.
      chipselect = 1'b1; write = 1'b1; address = 4'd4; writedata = 8'h11;
      set_b();
      tick();
      do_write(4'd4, 8'h22);
      checks++;
      if (ball_y !== 8'h11) begin
         errors++;
         $display("[TB] FAIL b2b_first ball_y got %h want 11", ball_y);
      end
      do_read(4'd6);
      checks++;
      if (readdata !== 8'h01 || ball_y !== 8'h11) begin
         errors++;
         $display("[TB] FAIL b2b_pending status=%h ball_y=%h want 01 11",
                  readdata, ball_y);
      end
      set_b();
      tick();
      tick();
      checks++;
      if (ball_y !== 8'h22) begin
         errors++;
         $display("[TB] FAIL b2b_second ball_y got %h want 22", ball_y);
      end
   endtask

   task automatic test_irq();
      do_write(4'd5, 8'h02);
      set_b();
      tick();
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("[TB] FAIL irq_set got %b want 1", irq);
      end
      do_read(4'd6);
      checks++;
      if (readdata !== 8'h02) begin
         errors++;
         $display("[TB] FAIL irq_status got %h want 02", readdata);
      end
      do_write(4'd6, 8'h02);
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("[TB] FAIL irq_clear got %b want 0", irq);
      end
      chipselect = 1'b1; write = 1'b1; address = 4'd6; writedata = 8'h02;
      set_b();
      tick();
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("[TB] FAIL irq_set_wins got %b want 1", irq);
      end
      do_write(4'd5, 8'h00);
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("[TB] FAIL irq_en_clear_keeps got %b want 1", irq);
      end
      do_write(4'd6, 8'h02);
   endtask

   task automatic test_frame_cnt();
      reset = 1'b1;
      #1;
      model_reset();
      reset = 1'b0;
      for (int i = 0; i < 255; i++) begin
         set_b();
         tick();
         tick();
      end
      chipselect = 1'b1; read = 1'b1; address = 4'd7;
      #1;
      checks++;
      if (readdata !== 8'h00) begin
         errors++;
         $display("[TB] FAIL cnt_latency got %h want 00 before edge", readdata);
      end
      tick();
      checks++;
      if (readdata !== 8'd255) begin
         errors++;
         $display("[TB] FAIL cnt_255 got %0d want 255", readdata);
      end
      tick();
      checks++;
      if (readdata !== 8'd255) begin
         errors++;
         $display("[TB] FAIL cnt_hold got %0d want 255", readdata);
      end
      set_b();
      tick();
      do_read(4'd7);
      checks++;
      if (readdata !== 8'd0) begin
         errors++;
         $display("[TB] FAIL cnt_wrap got %0d want 0", readdata);
      end
      do_read(4'd12);
      checks++;
      if (readdata !== 8'd0) begin
         errors++;
         $display("[TB] FAIL read_unmapped got %h want 00", readdata);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 600; n++) begin
         chipselect = ($urandom_range(0, 3) != 0);
         write      = ($urandom_range(0, 2) == 0);
         read       = ($urandom_range(0, 1) == 0);
         address    = 4'($urandom_range(0, 15));
         writedata  = 8'($urandom);
         // Keep HOLD rare so commits still happen.
         if (address == 4'd5 && $urandom_range(0, 3) != 0)
            writedata[0] = 1'b0;
         if ($urandom_range(0, 7) == 0) set_b();
         tick();
         checks++;
         if ({bg_r, bg_g, bg_b, ball_x, ball_y} !==
             {m_act[0], m_act[1], m_act[2], m_act[3], m_act[4]}) begin
            errors++;
            $display("[TB] FAIL rand_active cyc %0d got %h%h%h%h%h want %h%h%h%h%h",
                     n, bg_r, bg_g, bg_b, ball_x, ball_y,
                     m_act[0], m_act[1], m_act[2], m_act[3], m_act[4]);
         end
         checks++;
         if ({readdata, irq, frame_sync} !== {m_rd, m_irq, m_sync}) begin
            errors++;
            $display("[TB] FAIL rand_misc cyc %0d rd=%h irq=%b sync=%b want %h %b %b",
                     n, readdata, irq, frame_sync, m_rd, m_irq, m_sync);
         end
      end
   endtask

   initial begin
      chipselect = 1'b0; write = 1'b0; read = 1'b0;
      address = 4'd0; writedata = 8'd0;
      set_idle();
      model_reset();
      reset = 1'b1;
      #12;
      reset = 1'b0;
      test_reset();
      test_commit();
      test_hold();
      test_back_to_back();
      test_irq();
      test_frame_cnt();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
